// File: rtl/freq_div_prog_multi.sv
// Multi-channel runtime-programmable clock-enable divider.
// Each channel divides clk by its own divisor; new divisors take effect at a period boundary or while idle.
module freq_div_prog_multi #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 24,
    parameter int DEFAULT_DIV = 10000000,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             sync,
    input  logic             load,
    input  logic [CH_W-1:0]  load_ch,
    input  logic [CNT_W-1:0] load_div,
    output logic [N_CH-1:0]  div_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pend
);

    logic [CNT_W-1:0] cnt [N_CH];
    logic [CNT_W-1:0] div [N_CH];
    logic [CNT_W-1:0] nxt [N_CH];
    logic [CNT_W:0]   half [N_CH];
    logic [N_CH-1:0]  wrap;
    logic [N_CH-1:0]  idle;
    logic [N_CH-1:0]  load_hit;
    logic [CNT_W-1:0] load_val;

    // Half period is computed one bit wider so the maximum divisor cannot overflow.
    always_comb begin
        load_val = (load_div < CNT_W'(2)) ? CNT_W'(2) : load_div;
        wrap     = '0;
        idle     = '0;
        load_hit = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            half[i]     = ({1'b0, div[i]} + (CNT_W+1)'(1)) >> 1;
            wrap[i]     = (cnt[i] == div[i] - CNT_W'(1));
            idle[i]     = sync || !en[i];
            load_hit[i] = load && (32'(load_ch) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
                div[i] <= CNT_W'(DEFAULT_DIV);
                nxt[i] <= CNT_W'(DEFAULT_DIV);
            end
            pend    <= '0;
            div_out <= '0;
            tick    <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (idle[i]) begin
                    cnt[i]     <= '0;
                    div_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else begin
                    div_out[i] <= ({1'b0, cnt[i]} < half[i]);
                    tick[i]    <= (cnt[i] == '0);
                    cnt[i]     <= wrap[i] ? '0 : cnt[i] + CNT_W'(1);
                end
                if (pend[i] && (idle[i] || wrap[i])) begin
                    div[i]  <= nxt[i];
                    pend[i] <= 1'b0;
                end
                // A load landing on the apply cycle re-arms pend so it is never lost.
                if (load_hit[i]) begin
                    nxt[i]  <= load_val;
                    pend[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_div_prog_multi.sv
// Bench for freq_div_prog_multi: directed scenarios then random traffic,
// checked every cycle against a period-position reference model.
`timescale 1ns/100ps
module tb_freq_div_prog_multi;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int DD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] en = '1;
    logic         sync = 1'b0;
    logic         load = 1'b0;
    logic [1:0]   load_ch = '0;
    logic [W-1:0] load_div = '0;
    logic [N-1:0] div_out, tick, pend;

    int total = 0;
    int bad   = 0;

    // Model: position within the current period, active/pending divisors.
    int           m_pos [N];
    int           m_d   [N];
    int           m_nxt [N];
    logic [N-1:0] e_out, e_tick, e_pend;

    freq_div_prog_multi #(.N_CH(N), .CNT_W(W), .DEFAULT_DIV(DD)) dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync), .load(load),
        .load_ch(load_ch), .load_div(load_div),
        .div_out(div_out), .tick(tick), .pend(pend)
    );

    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_pos[i] = 0; m_d[i] = DD; m_nxt[i] = DD;
                e_pend[i] = 1'b0; e_out[i] = 1'b0; e_tick[i] = 1'b0;
            end else begin
                if (sync || !en[i]) begin
                    e_out[i] = 1'b0; e_tick[i] = 1'b0; m_pos[i] = 0;
                    if (e_pend[i]) begin m_d[i] = m_nxt[i]; e_pend[i] = 1'b0; end
                end else begin
                    e_out[i]  = (m_pos[i] < (m_d[i] + 1) / 2);
                    e_tick[i] = (m_pos[i] == 0);
                    m_pos[i]  = m_pos[i] + 1;
                    if (m_pos[i] == m_d[i]) begin
                        m_pos[i] = 0;
                        if (e_pend[i]) begin m_d[i] = m_nxt[i]; e_pend[i] = 1'b0; end
                    end
                end
                if (load && int'(load_ch) == i) begin
                    m_nxt[i]  = (int'(load_div) < 2) ? 2 : int'(load_div);
                    e_pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #0.5;
        check({tag, "_div_out"}, div_out, e_out);
        check({tag, "_tick"}, tick, e_tick);
        check({tag, "_pend"}, pend, e_pend);
    endtask

    task automatic do_load(input int ch, input int d, input string tag);
        load = 1'b1; load_ch = 2'(ch); load_div = W'(d);
        cyc(tag);
        load = 1'b0;
    endtask

    initial begin
        // 1: reset then free-running default divide-by-4
        reset = 1'b1; en = '1;
        repeat (5) cyc("rst");
        check("rst_out_zero", div_out, '0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc("s1");
            check("s1_pattern", div_out, ((k % 4) < 2) ? 4'hF : 4'h0);
            check("s1_tick", tick, ((k % 4) == 0) ? 4'hF : 4'h0);
        end

        // 2: mid-period load on ch1, applied at its next wrap
        cyc("s2_pre");
        do_load(1, 5, "s2_load");
        check("s2_pend_set", pend, 4'b0010);
        repeat (14) cyc("s2_run");

        // 3: load of 0 clamps to 2; ch3 gets 6 for the sync scenario
        do_load(2, 0, "s3_load0");
        repeat (6) cyc("s3_run");
        do_load(3, 6, "s3_load3");
        repeat (8) cyc("s3_run2");

        // 4: skew ch3, then sync realigns everything
        en = 4'b0111;
        repeat (3) cyc("s4_skew");
        en = 4'hF;
        repeat (9) cyc("s4_run");
        sync = 1'b1;
        cyc("s4_sync");
        sync = 1'b0;
        check("s4_sync_low", div_out, 4'h0);
        cyc("s4_restart");
        check("s4_tick_align", tick, 4'hF);
        check("s4_rise_align", div_out, 4'hF);
        repeat (6) cyc("s4_after");

        // 5: disabling a channel applies its pending divisor immediately
        do_load(1, 7, "s5_load");
        en[1] = 1'b0;
        cyc("s5_idle");
        check("s5_pend_clear", pend & 4'b0010, 4'b0000);
        check("s5_out_low", div_out & 4'b0010, 4'b0000);
        en[1] = 1'b1;
        repeat (15) cyc("s5_run");

        // 6: reset mid-period with a pending load
        do_load(0, 3, "s6_load");
        cyc("s6_pre");
        reset = 1'b1;
        cyc("s6_reset");
        check("s6_out", div_out, 4'h0);
        check("s6_tick", tick, 4'h0);
        check("s6_pend", pend, 4'h0);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc("s6_run");
            check("s6_pattern", div_out, ((k % 4) < 2) ? 4'hF : 4'h0);
        end

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(15) == 0) en[$urandom_range(N-1)] ^= 1'b1;
            sync  = ($urandom_range(39) == 0);
            reset = ($urandom_range(249) == 0);
            load  = ($urandom_range(3) == 0);
            load_ch = 2'($urandom_range(N-1));
            load_div = ($urandom_range(19) == 0) ? W'($urandom_range(255)) : W'($urandom_range(12));
            cyc("rnd");
        end
        sync = 1'b0; load = 1'b0; reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
